// File: rtl/lsu_ctrl_if.sv
// Core/bus signal bundle for the load/store unit.
//
// Handshakes:
//   Core request: a request transfers on a rising clk edge where req_valid and
//   req_ready are both high; req_* fields must be held stable while req_valid
//   is high and req_ready is low.
//   Core response: resp_valid is a single-cycle pulse; resp_rdata/resp_err are
//   meaningful in that cycle and stay unchanged until the next pulse.
//   Bus request: bus_req stays high with bus_addr/bus_we/bus_wdata/bus_wstrb
//   stable until an edge where bus_gnt is high; that edge transfers the request.
//   Bus completion: bus_rvalid high on an edge completes the granted transfer
//   (bus_rdata carries the read word for loads).
interface lsu_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // core side
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [1:0]        req_size;
    logic              req_sext;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    // bus side
    logic              bus_req;
    logic              bus_gnt;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [3:0]        bus_wstrb;
    logic              bus_rvalid;
    logic [DATA_W-1:0] bus_rdata;

    // LSU view
    modport slave (
        input  req_valid, req_wen, req_size, req_sext, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    // Environment view (core + memory bus)
    modport master (
        output req_valid, req_wen, req_size, req_sext, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit: accepts one core access at a time, runs it on the
// word-wide handshaked bus, aligns/extends load data and pulses resp_valid.
// Only DATA_W = 32 is supported.
module lsu_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    lsu_ctrl_if.slave  lsu,
    output logic [1:0] o_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;

    // latched request
    logic              r_wen;
    logic              r_sext;
    logic              r_err;
    logic [1:0]        r_size;
    logic [1:0]        r_lane;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_wdata;
    logic [3:0]        r_bus_wstrb;

    // response registers
    logic [DATA_W-1:0] r_resp_rdata;
    logic              r_resp_err;

    logic              w_accept;
    logic              w_err;
    logic [DATA_W-1:0] w_wdata_lane;
    logic [3:0]        w_wstrb;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_load_data;

    assign w_accept = lsu.req_valid && (r_state == S_IDLE);

    // Decode illegal size and misalignment of the incoming request
    always_comb begin
        w_err = 1'b0;
        case (lsu.req_size)
            2'b01:   w_err = lsu.req_addr[0];
            2'b10:   w_err = (lsu.req_addr[1:0] != 2'b00);
            2'b11:   w_err = 1'b1;
            default: w_err = 1'b0;
        endcase
    end

    // Replicate store data across lanes and build byte enables
    always_comb begin
        w_wdata_lane = '0;
        w_wstrb      = 4'b0000;
        if (lsu.req_wen) begin
            case (lsu.req_size)
                2'b00: begin
                    w_wdata_lane = {4{lsu.req_wdata[7:0]}};
                    w_wstrb      = 4'b0001 << lsu.req_addr[1:0];
                end
                2'b01: begin
                    w_wdata_lane = {2{lsu.req_wdata[15:0]}};
                    w_wstrb      = lsu.req_addr[1] ? 4'b1100 : 4'b0011;
                end
                2'b10: begin
                    w_wdata_lane = lsu.req_wdata;
                    w_wstrb      = 4'b1111;
                end
                default: begin
                    w_wdata_lane = '0;
                    w_wstrb      = 4'b0000;
                end
            endcase
        end
    end

    // Select the addressed lane of the read word and extend it
    always_comb begin
        w_byte      = 8'h00;
        w_half      = 16'h0000;
        w_load_data = '0;
        case (r_lane)
            2'd0:    w_byte = lsu.bus_rdata[7:0];
            2'd1:    w_byte = lsu.bus_rdata[15:8];
            2'd2:    w_byte = lsu.bus_rdata[23:16];
            default: w_byte = lsu.bus_rdata[31:24];
        endcase
        w_half = r_lane[1] ? lsu.bus_rdata[31:16] : lsu.bus_rdata[15:0];
        case (r_size)
            2'b00:   w_load_data = {{24{r_sext & w_byte[7]}}, w_byte};
            2'b01:   w_load_data = {{16{r_sext & w_half[15]}}, w_half};
            default: w_load_data = lsu.bus_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic. A rejected access (misaligned / illegal size) spends
    // one cycle in WAIT without touching the bus, which gives it a fixed
    // accept-to-response latency of two cycles; bus_rvalid is ignored there.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (lsu.req_valid) w_next = w_err ? S_WAIT : S_REQ;
            S_REQ:  if (lsu.bus_gnt) w_next = S_WAIT;
            S_WAIT: if (r_err || lsu.bus_rvalid) w_next = S_RESP;
            S_RESP: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Latch the request on accept and capture the response on WAIT exit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wen        <= 1'b0;
            r_sext       <= 1'b0;
            r_err        <= 1'b0;
            r_size       <= 2'b00;
            r_lane       <= 2'b00;
            r_bus_addr   <= '0;
            r_bus_wdata  <= '0;
            r_bus_wstrb  <= 4'b0000;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wen       <= lsu.req_wen;
                r_sext      <= lsu.req_sext;
                r_err       <= w_err;
                r_size      <= lsu.req_size;
                r_lane      <= lsu.req_addr[1:0];
                r_bus_addr  <= {lsu.req_addr[ADDR_W-1:2], 2'b00};
                r_bus_wdata <= w_wdata_lane;
                r_bus_wstrb <= w_wstrb;
            end
            if ((r_state == S_WAIT) && (w_next == S_RESP)) begin
                r_resp_err   <= r_err;
                r_resp_rdata <= (r_err || r_wen) ? '0 : w_load_data;
            end
        end
    end

    // Outputs decoded from state; bus fields come straight from the latch
    assign lsu.req_ready  = (r_state == S_IDLE);
    assign lsu.resp_valid = (r_state == S_RESP);
    assign lsu.resp_rdata = r_resp_rdata;
    assign lsu.resp_err   = r_resp_err;
    assign lsu.bus_req    = (r_state == S_REQ);
    assign lsu.bus_we     = (r_state == S_REQ) && r_wen;
    assign lsu.bus_addr   = r_bus_addr;
    assign lsu.bus_wdata  = r_bus_wdata;
    assign lsu.bus_wstrb  = r_bus_wstrb;
    assign o_state        = r_state;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed accesses plus random traffic, a bus responder
// with programmable grant/completion delays, and a response monitor fed from
// an expected queue built by a behavioural model.
module tb_lsu_ctrl;

    logic       clk;
    logic       rst;
    logic [1:0] state_dbg;

    lsu_ctrl_if #(.ADDR_W(32), .DATA_W(32)) lsu ();

    lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .lsu     (lsu),
        .o_state (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [40:0] exp_q[$];   // {err, rdata, latency}
    int          acc_q[$];   // edge index at which each access was accepted
    logic [68:0] bus_q[$];   // {we, addr, wdata, wstrb}
    logic [32:0] last_resp;  // {err, rdata} of the most recent response

    int          cur_gnt_dly = 0;
    int          cur_rv_dly  = 0;
    logic [31:0] cur_rdata   = '0;
    logic        inj_rvalid  = 1'b0;

    task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'b11) return 1'b1;
        return (addr % (32'd1 << size)) != 32'd0;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic sext,
                                               input logic [31:0] addr, input logic [31:0] word);
        int          nbytes;
        int          sh;
        logic [31:0] mask;
        logic [31:0] val;
        nbytes = 1 << size;
        sh     = int'(addr % 32'd4);
        mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
        val    = (word >> (8 * sh)) & mask;
        if (sext && nbytes < 4 && val[8 * nbytes - 1]) val = val | ~mask;
        return val;
    endfunction

    function automatic logic [68:0] model_bus(input logic wen, input logic [1:0] size,
                                              input logic [31:0] addr, input logic [31:0] d);
        int          nbytes;
        int          sh;
        int          s;
        logic [31:0] wd;
        logic [3:0]  strb;
        nbytes = 1 << size;
        sh     = int'(addr % 32'd4);
        s      = ((1 << nbytes) - 1) << sh;
        strb   = wen ? s[3:0] : 4'b0000;
        wd     = '0;
        if (wen) begin
            for (int i = 0; i < 4; i++) wd[8*i +: 8] = d[8*(i % nbytes) +: 8];
        end
        return {wen, addr & 32'hFFFF_FFFC, wd, strb};
    endfunction

    // ---------------- driver tasks (called just after a negedge) ----------------
    task automatic issue(input logic wen, input logic [1:0] size, input logic sext,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int gdly, input int rdly);
        logic        err;
        logic [31:0] rd;
        int          lat;
        bit          ok;
        err = model_err(size, addr);
        rd  = (err || wen) ? 32'd0 : model_load(size, sext, addr, rdata);
        lat = err ? 2 : 3 + gdly + rdly;
        cur_gnt_dly   = gdly;
        cur_rv_dly    = rdly;
        cur_rdata     = rdata;
        lsu.req_valid = 1'b1;
        lsu.req_wen   = wen;
        lsu.req_size  = size;
        lsu.req_sext  = sext;
        lsu.req_addr  = addr;
        lsu.req_wdata = wdata;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (lsu.req_ready) begin
                ok = 1'b1;
                acc_q.push_back(cyc + 1);
                exp_q.push_back({err, rd, 8'(lat)});
                if (!err) bus_q.push_back(model_bus(wen, size, addr, wdata));
                last_resp = {err, rd};
            end
            @(negedge clk);
        end
        lsu.req_valid = 1'b0;
        lsu.req_addr  = $urandom;
        lsu.req_wdata = $urandom;
        lsu.req_size  = 2'($urandom_range(0, 3));
        if (!ok) check("accept_timeout", 69'(1), 69'(0));
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            check("resp_timeout", 69'(exp_q.size()), 69'(0));
            exp_q.delete();
            acc_q.delete();
        end
        @(negedge clk);
        check("resp_pulse_single", 69'(lsu.resp_valid), 69'(0));
        check("resp_held", 69'({lsu.resp_err, lsu.resp_rdata}), 69'(last_resp));
    endtask

    task automatic access(input logic wen, input logic [1:0] size, input logic sext,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int gdly, input int rdly);
        issue(wen, size, sext, addr, wdata, rdata, gdly, rdly);
        wait_done();
    endtask

    task automatic stray_rvalid();
        inj_rvalid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stray_rvalid_no_resp", 69'(lsu.resp_valid), 69'(0));
        end
    endtask

    // ---------------- bus responder ----------------
    initial begin : bus_responder
        int          b_ph;
        int          b_cnt;
        logic [68:0] b_exp;
        logic [68:0] b_act;
        b_ph  = 0;
        b_cnt = 0;
        b_exp = '0;
        lsu.bus_gnt    = 1'b0;
        lsu.bus_rvalid = 1'b0;
        lsu.bus_rdata  = '0;
        forever begin
            @(negedge clk);
            lsu.bus_gnt    = 1'b0;
            lsu.bus_rvalid = 1'b0;
            lsu.bus_rdata  = $urandom;
            if (rst) begin
                b_ph = 0;
            end else if (b_ph == 2) begin
                check("bus_req_low_in_wait", 69'(lsu.bus_req), 69'(0));
                if (b_cnt == 0) begin
                    lsu.bus_rvalid = 1'b1;
                    lsu.bus_rdata  = cur_rdata;
                    b_ph = 0;
                end else begin
                    b_cnt--;
                end
            end else begin
                if (b_ph == 0 && lsu.bus_req) begin
                    if (bus_q.size() == 0) begin
                        check("unexpected_bus_req", 69'(1), 69'(0));
                        b_exp = '0;
                    end else begin
                        b_exp = bus_q.pop_front();
                    end
                    b_ph  = 1;
                    b_cnt = cur_gnt_dly;
                end
                if (b_ph == 1) begin
                    b_act = {lsu.bus_we, lsu.bus_addr,
                             (b_exp[68] ? lsu.bus_wdata : 32'd0), lsu.bus_wstrb};
                    check("bus_req_fields", b_act, b_exp);
                    check("bus_req_high", 69'(lsu.bus_req), 69'(1));
                    if (b_cnt == 0) begin
                        lsu.bus_gnt = 1'b1;
                        b_ph  = 2;
                        b_cnt = cur_rv_dly;
                    end else begin
                        b_cnt--;
                    end
                end else if (inj_rvalid) begin
                    lsu.bus_rvalid = 1'b1;
                    inj_rvalid     = 1'b0;
                end
            end
        end
    end

    // ---------------- response monitor ----------------
    initial begin : monitor
        logic [40:0] e;
        logic [7:0]  lat;
        int          acc;
        forever begin
            @(negedge clk);
            if (!rst && lsu.resp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 69'(1), 69'(0));
                end else begin
                    e   = exp_q.pop_front();
                    acc = acc_q.pop_front();
                    lat = 8'(cyc + 1 - acc);
                    check("resp_err_rdata_latency",
                          69'({lsu.resp_err, lsu.resp_rdata, lat}), 69'(e));
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin : main
        rst = 1'b1;
        lsu.req_valid = 1'b0;
        lsu.req_wen   = 1'b0;
        lsu.req_size  = 2'b00;
        lsu.req_sext  = 1'b0;
        lsu.req_addr  = '0;
        lsu.req_wdata = '0;
        repeat (3) @(negedge clk);

        // reset values
        check("rst_req_ready",  69'(lsu.req_ready),  69'(1));
        check("rst_resp_valid", 69'(lsu.resp_valid), 69'(0));
        check("rst_resp_err",   69'(lsu.resp_err),   69'(0));
        check("rst_resp_rdata", 69'(lsu.resp_rdata), 69'(0));
        check("rst_bus_req",    69'(lsu.bus_req),    69'(0));
        check("rst_bus_we",     69'(lsu.bus_we),     69'(0));
        check("rst_bus_addr",   69'(lsu.bus_addr),   69'(0));
        check("rst_bus_wdata",  69'(lsu.bus_wdata),  69'(0));
        check("rst_bus_wstrb",  69'(lsu.bus_wstrb),  69'(0));
        rst = 1'b0;
        @(negedge clk);

        // word store, zero-wait bus
        access(1'b1, 2'b10, 1'b0, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0, 0, 0);
        // byte loads, lane 3, signed and unsigned
        access(1'b0, 2'b00, 1'b1, 32'h8000_0007, 32'h0, 32'h80FF_0000, 0, 0);
        access(1'b0, 2'b00, 1'b0, 32'h8000_0007, 32'h0, 32'h80FF_0000, 0, 0);
        // half store / half load in the upper lane
        access(1'b1, 2'b01, 1'b0, 32'h8000_0002, 32'h1234_ABCD, 32'h0, 0, 0);
        access(1'b0, 2'b01, 1'b1, 32'h8000_0002, 32'h0, 32'h8001_0000, 0, 0);
        // misaligned word and illegal size: error path, no bus access
        access(1'b0, 2'b10, 1'b0, 32'h8000_0001, 32'h0, 32'hFFFF_FFFF, 0, 0);
        access(1'b1, 2'b11, 1'b0, 32'h8000_0000, 32'h5555_AAAA, 32'h0, 0, 0);
        access(1'b0, 2'b01, 1'b1, 32'h8000_0003, 32'h0, 32'h0, 0, 0);
        // delayed grant and completion, then a stray completion while idle
        access(1'b1, 2'b00, 1'b0, 32'h8000_0011, 32'h0000_00A5, 32'h0, 3, 2);
        access(1'b0, 2'b10, 1'b0, 32'h8000_0010, 32'h0, 32'hCAFE_F00D, 3, 2);
        stray_rvalid();

        // reset while waiting for bus completion
        issue(1'b0, 2'b10, 1'b0, 32'h8000_0020, 32'h0, 32'h1111_2222, 0, 8);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_req_ready",  69'(lsu.req_ready),  69'(1));
        check("midrst_bus_req",    69'(lsu.bus_req),    69'(0));
        check("midrst_resp_valid", 69'(lsu.resp_valid), 69'(0));
        check("midrst_resp_rdata", 69'(lsu.resp_rdata), 69'(0));
        check("midrst_state_idle", 69'(state_dbg),      69'(0));
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        acc_q.delete();
        last_resp = '0;
        stray_rvalid();
        access(1'b0, 2'b00, 1'b1, 32'h8000_0021, 32'h0, 32'h0000_F700, 1, 0);

        // random traffic
        for (int n = 0; n < 80; n++) begin
            logic [1:0] sz;
            sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                   $urandom, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) stray_rvalid();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("queues_drained", 69'(exp_q.size() + bus_q.size()), 69'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
